// File: rtl/icache_pkg.sv
// Shared constants, FSM encoding and geometry helpers for the
// direct-mapped instruction cache.
package icache_pkg;

    localparam int LINE_WORDS  = 4;
    localparam int OFFSET_BITS = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    function automatic int tag_bits(input int index_bits);
        return 30 - index_bits - OFFSET_BITS;
    endfunction

endpackage

// File: rtl/icache_fill_ctrl.sv
// Line-fill sequencer: IDLE/FILL state, word counter, deferred flush
// and the backing-memory request/ack handshake.
module icache_fill_ctrl
    import icache_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_miss,
    input  logic                   i_flush,
    input  logic [29:0]            i_line_base,
    input  logic                   i_mem_ack,
    output logic                   o_busy,
    output logic                   o_start,
    output logic                   o_mem_req,
    output logic [29:0]            o_mem_addr,
    output logic                   o_we,
    output logic [OFFSET_BITS-1:0] o_word,
    output logic                   o_set_valid,
    output logic                   o_clear_all
);

    localparam logic [OFFSET_BITS-1:0] LAST_WORD =
        OFFSET_BITS'(LINE_WORDS - 1);

    state_e                   r_state;
    logic [OFFSET_BITS-1:0]   r_cnt;
    logic                     r_flush_pending;
    logic                     r_mem_req;
    logic [29:0]              r_mem_addr;

    logic w_fill;
    logic w_done;

    assign w_fill = (r_state == ST_FILL);
    assign w_done = w_fill && i_mem_ack && (r_cnt == LAST_WORD);

    // A miss in a flush cycle is deferred so it sees the cleared tags.
    assign o_busy      = w_fill;
    assign o_start     = !w_fill && i_miss && !i_flush;
    assign o_mem_req   = r_mem_req;
    assign o_mem_addr  = r_mem_addr;
    assign o_we        = w_fill && i_mem_ack;
    assign o_word      = r_cnt;
    assign o_set_valid = w_done && !r_flush_pending && !i_flush;
    assign o_clear_all = (!w_fill && i_flush) ||
                         (w_done && (r_flush_pending || i_flush));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_flush_pending <= 1'b0;
            r_mem_req       <= 1'b0;
            r_mem_addr      <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (o_start) begin
                        r_state    <= ST_FILL;
                        r_cnt      <= '0;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= i_line_base;
                    end
                end
                ST_FILL: begin
                    if (i_flush)
                        r_flush_pending <= 1'b1;
                    if (i_mem_ack) begin
                        r_cnt      <= r_cnt + 1'b1;
                        r_mem_addr <= r_mem_addr + 30'd1;
                        if (r_cnt == LAST_WORD) begin
                            r_state         <= ST_IDLE;
                            r_mem_req       <= 1'b0;
                            r_mem_addr      <= '0;
                            r_flush_pending <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped I-cache in front of the fetch port: combinational hit
// path, 4-word line fills over a slow handshaked memory.
module icache_fetch
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 4
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic [29:0] pc_word,
    output logic [31:0] inst,
    output logic        inst_ready,
    input  logic        flush,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] miss_count
);

    localparam int TAG_W = tag_bits(INDEX_BITS);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int AW    = INDEX_BITS + OFFSET_BITS;

    logic [31:0]      r_data [LINES*LINE_WORDS];
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [LINES-1:0] r_valid;
    logic [15:0]      r_miss_count;

    logic [INDEX_BITS-1:0]  w_index;
    logic [TAG_W-1:0]       w_tag;
    logic [AW-1:0]          w_rd_addr;
    logic [AW-1:0]          w_wr_addr;
    logic [INDEX_BITS-1:0]  w_fill_index;
    logic [29:0]            w_line_base;
    logic                   w_hit;
    logic                   w_busy;
    logic                   w_start;
    logic                   w_we;
    logic [OFFSET_BITS-1:0] w_word;
    logic                   w_set_valid;
    logic                   w_clear_all;

    assign w_rd_addr    = pc_word[AW-1:0];
    assign w_index      = pc_word[AW-1:OFFSET_BITS];
    assign w_tag        = pc_word[29:AW];
    assign w_line_base  = {pc_word[29:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign w_fill_index = mem_addr[AW-1:OFFSET_BITS];
    assign w_wr_addr    = {w_fill_index, w_word};

    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign inst       = r_data[w_rd_addr];
    assign inst_ready = !w_busy && w_hit;
    assign miss_count = r_miss_count;

    icache_fill_ctrl u_fill_ctrl (
        .clock       (clock),
        .reset       (reset),
        .i_miss      (!w_hit),
        .i_flush     (flush),
        .i_line_base (w_line_base),
        .i_mem_ack   (mem_ack),
        .o_busy      (w_busy),
        .o_start     (w_start),
        .o_mem_req   (mem_req),
        .o_mem_addr  (mem_addr),
        .o_we        (w_we),
        .o_word      (w_word),
        .o_set_valid (w_set_valid),
        .o_clear_all (w_clear_all)
    );

    always_ff @(posedge clock) begin
        if (w_we)
            r_data[w_wr_addr] <= mem_rdata;
        if (w_set_valid)
            r_tag[w_fill_index] <= mem_addr[29:AW];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid      <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_clear_all)
                r_valid <= '0;
            else if (w_set_valid)
                r_valid[w_fill_index] <= 1'b1;
            if (w_start && (r_miss_count != 16'hFFFF))
                r_miss_count <= r_miss_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch with a handshaked memory model
// returning 32'h1000_0000 + word address.
module tb_icache_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] pc_word = '0;
    logic        flush = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] inst;
    logic        inst_ready;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;
    int mem_wait = 0;
    int wcnt = 0;

    logic [31:0] sb[$];
    logic [29:0] addr_log[$];

    icache_fetch #(.INDEX_BITS(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .pc_word    (pc_word),
        .inst       (inst),
        .inst_ready (inst_ready),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .miss_count (miss_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_req !== 1'b1) begin
            mem_ack = 1'b0;
            wcnt = 0;
        end else if (wcnt >= mem_wait) begin
            mem_ack = 1'b1;
            mem_rdata = 32'h1000_0000 + {2'b00, mem_addr};
            wcnt = 0;
        end else begin
            mem_ack = 1'b0;
            wcnt++;
        end
    end

    always @(posedge clock)
        if (mem_req === 1'b1 && mem_ack === 1'b1)
            addr_log.push_back(mem_addr);

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        flush = 1'b0;
        pc_word = '0;
        mem_wait = 0;
        #2;
        checks++;
        if (inst_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b want 0", inst_ready);
        end
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req got %b want 0", mem_req);
        end
        checks++;
        if (mem_addr !== 30'h0) begin
            errors++;
            $display("FAIL reset_addr got %h want 0", mem_addr);
        end
        checks++;
        if (miss_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_miss got %h want 0", miss_count);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Starts and ends on a falling edge; exp_stall < 0 skips latency check.
    task automatic fetch(input logic [29:0] pc, input int exp_stall,
                         input string name);
        int stall;
        logic pr, pa;
        logic [29:0] paddr;
        logic [31:0] want;
        pc_word = pc;
        sb.push_back(32'h1000_0000 + {2'b00, pc});
        stall = 0;
        pr = 1'b0;
        pa = 1'b0;
        paddr = '0;
        forever begin
            #2;
            if (pr && !pa) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== paddr) begin
                    errors++;
                    $display("FAIL %s_hold got req %b addr %h want 1 %h",
                             name, mem_req, mem_addr, paddr);
                end
            end
            if (inst_ready === 1'b1) break;
            pr = mem_req;
            pa = mem_ack;
            paddr = mem_addr;
            stall++;
            if (stall > 100) begin
                errors++;
                $display("FAIL %s_timeout got no inst_ready want ready", name);
                void'(sb.pop_front());
                return;
            end
            @(negedge clock);
        end
        want = sb.pop_front();
        checks++;
        if (inst !== want) begin
            errors++;
            $display("FAIL %s_inst got %h want %h", name, inst, want);
        end
        if (exp_stall >= 0) begin
            checks++;
            if (stall != exp_stall) begin
                errors++;
                $display("FAIL %s_stall got %0d want %0d",
                         name, stall, exp_stall);
            end
        end
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_hitreq got %b want 0", name, mem_req);
        end
        @(negedge clock);
    endtask

    task automatic check_miss(input logic [15:0] want, input string name);
        checks++;
        if (miss_count !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, miss_count, want);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        addr_log.delete();
        fetch(30'h0, 5, "fill0");
        checks++;
        if (addr_log.size() != 4) begin
            errors++;
            $display("FAIL fill0_nreq got %0d want 4", addr_log.size());
        end
        for (int k = 0; k < 4 && k < addr_log.size(); k++) begin
            checks++;
            if (addr_log[k] !== 30'(k)) begin
                errors++;
                $display("FAIL fill0_addr%0d got %h want %h",
                         k, addr_log[k], k);
            end
        end
        check_miss(16'd1, "basic_miss");
        fetch(30'h1, 0, "hit1");
        fetch(30'h2, 0, "hit2");
        fetch(30'h3, 0, "hit3");
        check_miss(16'd1, "hits_miss");
    endtask

    task automatic test_conflict();
        fetch(30'h40, 5, "conf40");
        fetch(30'h0, 5, "conf0");
        check_miss(16'd3, "conflict_miss");
        fetch(30'h2, 0, "conf_hit");
    endtask

    task automatic test_slow_mem();
        apply_reset();
        mem_wait = 2;
        fetch(30'h100, 13, "slow");
        fetch(30'h103, 0, "slow_hit");
        mem_wait = 0;
        check_miss(16'd1, "slow_miss");
    endtask

    task automatic test_flush();
        apply_reset();
        fetch(30'h0, 5, "fl_fill");
        flush = 1'b1;
        #2;
        checks++;
        if (inst_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle_hit got %b want 1", inst_ready);
        end
        @(negedge clock);
        flush = 1'b0;
        fetch(30'h0, 5, "fl_refill");
        check_miss(16'd2, "flush_idle_miss");
        pc_word = 30'h20;
        for (int k = 0; k < 5; k++) begin
            #2;
            if (k == 2) flush = 1'b1;
            @(negedge clock);
            flush = 1'b0;
        end
        #2;
        checks++;
        if (inst_ready !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_fill_end got ready %b req %b want 0 0",
                     inst_ready, mem_req);
        end
        check_miss(16'd3, "flush_fill_miss");
        @(negedge clock);
        fetch(30'h20, 4, "fl_after");
        check_miss(16'd4, "flush_refetch_miss");
        fetch(30'h0, 5, "fl_line0");
    endtask

    task automatic test_reset_midfill();
        bit found;
        apply_reset();
        pc_word = 30'h0;
        found = 1'b0;
        repeat (20) begin
            #2;
            if (mem_req === 1'b1 && mem_addr === 30'h2) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_reach got none want word2 request");
        end
        reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || inst_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got req %b ready %b want 0 0",
                     mem_req, inst_ready);
        end
        check_miss(16'd0, "rst_miss_clear");
        @(negedge clock);
        reset = 1'b1;
        addr_log.delete();
        fetch(30'h0, 5, "rst_fill");
        checks++;
        if (addr_log.size() == 0 || addr_log[0] !== 30'h0) begin
            errors++;
            $display("FAIL rst_first_word got %0d entries want word 0 first",
                     addr_log.size());
        end
        check_miss(16'd1, "rst_miss_restart");
    endtask

    task automatic test_saturate();
        apply_reset();
        fetch(30'h0, 5, "sat_fill");
        force dut.r_miss_count = 16'hFFFE;
        #1;
        release dut.r_miss_count;
        check_miss(16'hFFFE, "sat_forced");
        @(negedge clock);
        fetch(30'h40, 5, "sat_a");
        check_miss(16'hFFFF, "sat_first");
        fetch(30'h0, 5, "sat_b");
        check_miss(16'hFFFF, "sat_hold");
    endtask

    initial begin
        test_basic();
        test_conflict();
        test_slow_mem();
        test_flush();
        test_reset_midfill();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

endmodule
